// File: rtl/tgt_pyld_recv_mq_if.sv
// tgt_pyld_recv_mq_if: descriptor, payload-in and payload-out streams
// for the target-side payload receive stage.
//
// Ports (signals):
//   nxt_valid/nxt_qnum/nxt_ready      queue-number descriptor stream
//   in_valid/in_last/in_head/in_data  payload beats from upstream
//   in_ready                          payload beat accepted
//   out_valid/out_last/out_blen       registered output beat and tags
//   out_qnum/out_data
//   out_ready                         downstream accept
// Modports:
//   slave   the receive stage (tgt_pyld_recv_mq)
//   master  the surrounding logic driving descriptors/payload
interface tgt_pyld_recv_mq_if #(
    parameter int QUEUE_NUM_LOG = 4,
    parameter int DATA_W        = 256,
    parameter int HEAD_W        = 128,
    parameter int BLEN_W        = 13
);
    logic                     nxt_valid;
    logic [QUEUE_NUM_LOG-1:0] nxt_qnum;
    logic                     nxt_ready;

    logic                     in_valid;
    logic                     in_last;
    logic [HEAD_W-1:0]        in_head;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;

    logic                     out_valid;
    logic                     out_last;
    logic [BLEN_W-1:0]        out_blen;
    logic [QUEUE_NUM_LOG-1:0] out_qnum;
    logic [DATA_W-1:0]        out_data;
    logic                     out_ready;

    modport slave (
        input  nxt_valid, nxt_qnum,
        input  in_valid, in_last, in_head, in_data,
        input  out_ready,
        output nxt_ready, in_ready,
        output out_valid, out_last, out_blen, out_qnum, out_data
    );

    modport master (
        output nxt_valid, nxt_qnum,
        output in_valid, in_last, in_head, in_data,
        output out_ready,
        input  nxt_ready, in_ready,
        input  out_valid, out_last, out_blen, out_qnum, out_data
    );
endinterface

// File: rtl/tgt_pyld_recv_mq.sv
// tgt_pyld_recv_mq: target-side payload receive stage. Pairs each payload
// packet with a queue descriptor, looks the queue up in a per-queue drop
// table, sinks dropped packets at full rate and forwards passed packets
// through a registered output stage tagged with queue number and length.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   init_end          drop-table initialisation sweep finished
//   bus (slave)       descriptor / payload-in / payload-out streams
//   dropped_wen       drop-table write strobe (ignored until init_end)
//   dropped_qnum      drop-table write index
//   dropped_data      1 = drop, 0 = pass
//   cnt_clr           synchronous clear of both packet counters
//   pass_pkt_cnt      saturating count of passed packets
//   drop_pkt_cnt      saturating count of dropped packets
module tgt_pyld_recv_mq #(
    parameter int QUEUE_NUM_LOG = 4,
    parameter int DATA_W        = 256,
    parameter int HEAD_W        = 128,
    parameter int BLEN_W        = 13,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     init_end,
    tgt_pyld_recv_mq_if.slave        bus,
    input  logic                     dropped_wen,
    input  logic [QUEUE_NUM_LOG-1:0] dropped_qnum,
    input  logic                     dropped_data,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         pass_pkt_cnt,
    output logic [CNT_W-1:0]         drop_pkt_cnt
);

    localparam int TAB_N = 1 << QUEUE_NUM_LOG;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_DROP = 3'b010;
    localparam logic [2:0] S_PASS = 3'b100;

    localparam logic [QUEUE_NUM_LOG-1:0] IDX_LAST = '1;
    localparam logic [QUEUE_NUM_LOG-1:0] IDX_ONE  = 1;
    localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]         CNT_ONE  = 1;

    // init sweep and drop table
    logic                     init_q;
    logic [QUEUE_NUM_LOG-1:0] idx_q;
    logic [TAB_N-1:0]         tab_q;

    // packet FSM
    logic [2:0]               state_q, state_d;
    logic [QUEUE_NUM_LOG-1:0] cur_qnum_q, cur_qnum_d;

    // output register
    logic                     out_valid_q;
    logic                     out_last_q;
    logic [BLEN_W-1:0]        out_blen_q;
    logic [QUEUE_NUM_LOG-1:0] out_qnum_q;
    logic [DATA_W-1:0]        out_data_q;

    // statistics
    logic [CNT_W-1:0]         pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;

    // handshake decode
    logic in_rdy;
    logic nxt_rdy;
    logic in_fire;
    logic last_fire;
    logic desc_fire;
    logic is_pass;
    logic is_drop;
    logic out_load;

    // only the byte-length field of the head is consumed here
    logic unused_head;
    assign unused_head = ^bus.in_head[HEAD_W-1:BLEN_W];

    // ------------------------------------------------------------
    // Init sweep marks every queue as drop; host writes are only
    // honoured once the sweep has finished.
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            idx_q  <= '0;
            tab_q  <= '0;
        end else if (!init_q) begin
            tab_q[idx_q] <= 1'b1;
            idx_q        <= idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) begin
                init_q <= 1'b1;
            end
        end else if (dropped_wen) begin
            tab_q[dropped_qnum] <= dropped_data;
        end
    end

    // ------------------------------------------------------------
    // FSM: descriptor pop, disposition lookup, packet boundaries.
    // The disposition is frozen in the state at descriptor time, so
    // table writes mid-packet only affect later packets.
    // ------------------------------------------------------------
    assign is_pass = (state_q == S_PASS);
    assign is_drop = (state_q == S_DROP);

    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            S_DROP:  in_rdy = 1'b1;
            S_PASS:  in_rdy = ~out_valid_q | bus.out_ready;
            default: in_rdy = 1'b0;
        endcase
    end

    assign in_fire   = bus.in_valid & in_rdy;
    assign last_fire = in_fire & bus.in_last;

    // Next descriptor is popped in IDLE, or in the cycle the current
    // packet's last beat is accepted so packets run back-to-back.
    assign nxt_rdy   = (state_q == S_IDLE) ? init_q : last_fire;
    assign desc_fire = bus.nxt_valid & nxt_rdy;

    always_comb begin
        state_d    = state_q;
        cur_qnum_d = cur_qnum_q;
        case (state_q)
            S_IDLE, S_DROP, S_PASS: begin
                if (last_fire) begin
                    state_d = S_IDLE;
                end
                if (desc_fire) begin
                    cur_qnum_d = bus.nxt_qnum;
                    state_d    = tab_q[bus.nxt_qnum] ? S_DROP : S_PASS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_qnum_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_qnum_q <= cur_qnum_d;
        end
    end

    // ------------------------------------------------------------
    // Registered output stage. Holds while stalled; empties on
    // out_ready when no new beat is loaded.
    // ------------------------------------------------------------
    assign out_load = in_fire & is_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_blen_q  <= '0;
            out_qnum_q  <= '0;
            out_data_q  <= '0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_last_q  <= bus.in_last;
            out_blen_q  <= bus.in_head[BLEN_W-1:0];
            out_qnum_q  <= cur_qnum_q;
            out_data_q  <= bus.in_data;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------
    // Saturating packet counters; clear wins over increment.
    // ------------------------------------------------------------
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (cnt_clr) begin
            pass_cnt_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (last_fire && is_pass && pass_cnt_q != CNT_MAX) begin
                pass_cnt_d = pass_cnt_q + CNT_ONE;
            end
            if (last_fire && is_drop && drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign init_end      = init_q;
    assign bus.nxt_ready = nxt_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_blen  = out_blen_q;
    assign bus.out_qnum  = out_qnum_q;
    assign bus.out_data  = out_data_q;
    assign pass_pkt_cnt  = pass_cnt_q;
    assign drop_pkt_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tgt_pyld_recv_mq.sv
// tb_tgt_pyld_recv_mq: randomized packets against a transaction-level
// model of the receive stage (table, expected beats, counters).
module tb_tgt_pyld_recv_mq;

    localparam int L    = 4;
    localparam int DW   = 64;
    localparam int HW   = 32;
    localparam int BW   = 13;
    localparam int CW   = 4;
    localparam int NQ   = 1 << L;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MAXP = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tgt_pyld_recv_mq_if #(
        .QUEUE_NUM_LOG(L), .DATA_W(DW), .HEAD_W(HW), .BLEN_W(BW)
    ) bus ();

    logic          init_end;
    logic          dropped_wen;
    logic [L-1:0]  dropped_qnum;
    logic          dropped_data;
    logic          cnt_clr;
    logic [CW-1:0] pass_pkt_cnt;
    logic [CW-1:0] drop_pkt_cnt;

    tgt_pyld_recv_mq #(
        .QUEUE_NUM_LOG(L), .DATA_W(DW), .HEAD_W(HW),
        .BLEN_W(BW), .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_end     (init_end),
        .bus          (bus),
        .dropped_wen  (dropped_wen),
        .dropped_qnum (dropped_qnum),
        .dropped_data (dropped_data),
        .cnt_clr      (cnt_clr),
        .pass_pkt_cnt (pass_pkt_cnt),
        .drop_pkt_cnt (drop_pkt_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [L-1:0]  q;
        logic [BW-1:0] b;
    } beat_t;

    int errs = 0;
    int checks = 0;

    // packets of the current run
    logic [L-1:0]  pk_q [MAXP];
    int            pk_n [MAXP];
    logic [HW-1:0] pk_h [MAXP];
    logic [DW-1:0] pk_d [MAXP][4];
    int np;

    // reference model
    bit [NQ-1:0] mtab;
    bit          m_act;
    bit          m_drop;
    int          m_pass;
    int          m_dcnt;
    int          m_edges;
    beat_t       exp_q[$];

    // stall snapshot
    bit            prev_stall;
    logic [DW-1:0] h_d;
    logic [17:0]   h_t;

    // driver position
    int d_i, p_i, b_i;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic reset_dut();
        rst_n            = 1'b0;
        bus.nxt_valid    = 1'b0;
        bus.nxt_qnum     = '0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.in_head      = '0;
        bus.in_data      = '0;
        bus.out_ready    = 1'b0;
        dropped_wen      = 1'b0;
        dropped_qnum     = '0;
        dropped_data     = 1'b0;
        cnt_clr          = 1'b0;
        #1;
        chk("rst_init_end", init_end, 0);
        chk("rst_nxt_ready", bus.nxt_ready, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_qnum", bus.out_qnum, 0);
        chk("rst_out_blen", bus.out_blen, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_pass_cnt", pass_pkt_cnt, 0);
        chk("rst_drop_cnt", drop_pkt_cnt, 0);
        mtab       = '1;
        m_act      = 1'b0;
        m_drop     = 1'b0;
        m_pass     = 0;
        m_dcnt     = 0;
        m_edges    = 0;
        prev_stall = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cycle(input bit clr_en, input int ordy);
        bit    exp_ir, exp_nr, ifire, nfire, lastb;
        bit    idone;
        beat_t e;
        @(negedge clk);
        idone = (m_edges >= NQ);
        chk("init_end", init_end, idone);
        chk("pass_cnt", pass_pkt_cnt, m_pass);
        chk("drop_cnt", drop_pkt_cnt, m_dcnt);
        if (!m_act)      exp_ir = 1'b0;
        else if (m_drop) exp_ir = 1'b1;
        else             exp_ir = !bus.out_valid || bus.out_ready;
        chk("in_ready", bus.in_ready, exp_ir);
        exp_nr = m_act ? (bus.in_valid && bus.in_last && exp_ir) : idone;
        chk("nxt_ready", bus.nxt_ready, exp_nr);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (prev_stall) begin
            chk("hold_data", bus.out_data, h_d);
            chk("hold_tag", {bus.out_last, bus.out_qnum, bus.out_blen}, h_t);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_extra", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("out_last", bus.out_last, e.l);
                chk("out_qnum", bus.out_qnum, e.q);
                chk("out_blen", bus.out_blen, e.b);
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        h_d = bus.out_data;
        h_t = {bus.out_last, bus.out_qnum, bus.out_blen};

        ifire = bus.in_valid && bus.in_ready;
        nfire = bus.nxt_valid && bus.nxt_ready;
        if (ifire && m_act && p_i < np) begin
            lastb = (b_i == pk_n[p_i] - 1);
            if (!m_drop) begin
                e.d = pk_d[p_i][b_i];
                e.l = lastb;
                e.q = pk_q[p_i];
                e.b = pk_h[p_i][BW-1:0];
                exp_q.push_back(e);
            end
            if (lastb) begin
                if (m_drop) m_dcnt = sat_inc(m_dcnt);
                else        m_pass = sat_inc(m_pass);
                m_act = 1'b0;
            end
        end
        if (cnt_clr) begin
            m_pass = 0;
            m_dcnt = 0;
        end
        if (nfire && d_i < np) begin
            m_act  = 1'b1;
            m_drop = mtab[pk_q[d_i]];
        end
        if (dropped_wen && idone) mtab[dropped_qnum] = dropped_data;

        if (ifire && p_i < np) begin
            if (b_i == pk_n[p_i] - 1) begin
                b_i = 0;
                p_i++;
            end else begin
                b_i++;
            end
        end
        if (nfire) d_i++;

        @(posedge clk);
        m_edges++;
        #1;
        if (nfire) bus.nxt_valid = 1'b0;
        if (!bus.nxt_valid && d_i < np && $urandom_range(3) != 0) begin
            bus.nxt_valid = 1'b1;
            bus.nxt_qnum  = pk_q[d_i];
        end
        if (ifire) bus.in_valid = 1'b0;
        if (!bus.in_valid && p_i < np && $urandom_range(3) != 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pk_d[p_i][b_i];
            bus.in_last  = (b_i == pk_n[p_i] - 1);
            bus.in_head  = pk_h[p_i];
        end
        bus.out_ready = ($urandom_range(99) < ordy);
        dropped_wen   = ($urandom_range(5) == 0);
        dropped_qnum  = L'($urandom_range(NQ - 1));
        dropped_data  = $urandom_range(1) != 0;
        cnt_clr       = clr_en && ($urandom_range(19) == 0);
    endtask

    task automatic run(input int n, input int maxc, input bit clr_en,
                       input int ordy, input bit need_done);
        int c;
        np = n;
        for (int i = 0; i < n; i++) begin
            pk_q[i] = L'($urandom_range(NQ - 1));
            pk_n[i] = $urandom_range(4, 1);
            pk_h[i] = $urandom;
            for (int j = 0; j < 4; j++) pk_d[i][j] = {$urandom, $urandom};
        end
        pk_q[0] = 4'd3;
        pk_n[0] = 3;
        d_i = 0;
        p_i = 0;
        b_i = 0;
        c   = 0;
        while ((p_i < np || exp_q.size() != 0) && c < maxc) begin
            cycle(clr_en, ordy);
            c++;
        end
        dropped_wen = 1'b0;
        cnt_clr     = 1'b0;
        if (need_done) begin
            chk("pkts_done", p_i, np);
            chk("out_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        reset_dut();
        run(60, 3000, 1'b0, 60, 1'b1);
        run(40, 3000, 1'b1, 90, 1'b1);
        run(20, 19, 1'b0, 100, 1'b0);
        #2;
        reset_dut();
        run(8, 1000, 1'b1, 50, 1'b1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
